// File: rtl/sync_frame_parser_if.sv
// Byte-stream bundle for sync_frame_parser: upstream input stream plus
// downstream payload stream, both valid/ready handshakes.
// slave  : the parser side (consumes in_*, produces out_*).
// master : the environment side (produces in_*, consumes out_*).
interface sync_frame_parser_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last
   );
endinterface

// File: rtl/sync_frame_parser.sv
// sync_frame_parser: hunts for SYNC_BYTE, reads a length byte L, forwards
// L payload bytes through a single output register (out_last on the L-th),
// then optionally checks an XOR checksum byte.
// Optional feature macro: SYNC_FRAME_PARSER_CHECKSUM_EN
//   defined   -> CSUM state and running XOR checksum; err_code 10 on mismatch.
//   undefined -> frame_ok pulses right after the L-th payload byte.
module sync_frame_parser #(
   parameter logic [7:0]  SYNC_BYTE = 8'hAA,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   sync_frame_parser_if.slave     bus,
   output logic                   frame_ok,
   output logic                   frame_err,
   output logic [1:0]             err_code,
   output logic [15:0]            frame_count
);

   localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;
`else
   typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;
`endif

   state_t     state;
   logic [7:0] remain;
   logic       accept;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   // Upstream is always accepted outside PAYLOAD; inside PAYLOAD only when the
   // output register is free or draining this cycle.
   always_comb begin
      bus.in_ready = 1'b0;
      if (!rst)
         bus.in_ready = (state != PAYLOAD) || !bus.out_valid || bus.out_ready;
      accept = bus.in_valid && bus.in_ready;
   end

   // Frame FSM with registered payload output, status pulses and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= HUNT;
         remain        <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         frame_ok      <= 1'b0;
         frame_err     <= 1'b0;
         err_code      <= '0;
         frame_count   <= '0;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
         csum          <= '0;
`endif
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;

         // A pending payload byte drains independently of the frame state.
         if (bus.out_valid && bus.out_ready)
            bus.out_valid <= 1'b0;

         case (state)
            HUNT: begin
               if (accept && bus.in_data == SYNC_BYTE)
                  state <= LEN;
            end

            LEN: begin
               if (accept) begin
                  if (bus.in_data == 8'd0 || bus.in_data > MAX_LEN_B) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b01;
                     state     <= HUNT;
                  end else begin
                     remain <= bus.in_data;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
                     csum   <= bus.in_data;
`endif
                     state  <= PAYLOAD;
                  end
               end
            end

            PAYLOAD: begin
               if (accept) begin
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= bus.in_data;
                  bus.out_last  <= (remain == 8'd1);
                  remain        <= remain - 8'd1;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
                  csum          <= csum ^ bus.in_data;
                  if (remain == 8'd1)
                     state <= CSUM;
`else
                  if (remain == 8'd1) begin
                     frame_ok    <= 1'b1;
                     err_code    <= 2'b00;
                     frame_count <= frame_count + 16'd1;
                     state       <= HUNT;
                  end
`endif
               end
            end

`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  if (bus.in_data == csum) begin
                     frame_ok    <= 1'b1;
                     err_code    <= 2'b00;
                     frame_count <= frame_count + 16'd1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'b10;
                  end
                  state <= HUNT;
               end
            end
`endif

            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_frame_parser.sv
// Bench for sync_frame_parser: directed frames plus random frame streams,
// checked against a frame-level parse of the sent byte stream.
module tb_sync_frame_parser;

   localparam logic [7:0]  SYNC    = 8'hAA;
   localparam int unsigned MAX_LEN = 16;

   typedef struct {
      bit          ok;
      logic [1:0]  code;
      logic [15:0] cnt;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        frame_ok;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [15:0] frame_count;

   sync_frame_parser_if bus ();

   sync_frame_parser #(
      .SYNC_BYTE (SYNC),
      .MAX_LEN   (MAX_LEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .frame_ok    (frame_ok),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .frame_count (frame_count)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [7:0]  stim [$];
   logic [8:0]  exp_out [$];
   ev_t         exp_ev [$];
   logic [15:0] mcount   = '0;
   logic [1:0]  cur_code = '0;
   logic [15:0] cur_cnt  = '0;
   bit          mon_en     = 0;
   bit          prev_stall = 0;
   logic [8:0]  prev_word  = '0;
   int unsigned rdy_mode   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // out_ready pattern: 0 always, 1 toggling, 2 random, 3 held low
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ~bus.out_ready;
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: payload transfers, status pulses, held status, stall stability.
   initial begin
      ev_t e;
      logic [8:0] w;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(bus.out_valid), 1);
               chk("hold_data", 32'({bus.out_last, bus.out_data}), 32'(prev_word));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_out.size() == 0) chk("out_extra", exp_out.size(), 1);
               else begin
                  w = exp_out.pop_front();
                  chk("out_byte", 32'({bus.out_last, bus.out_data}), 32'(w));
               end
            end
            if (frame_ok || frame_err) begin
               if (exp_ev.size() == 0) chk("ev_extra", exp_ev.size(), 1);
               else begin
                  e = exp_ev.pop_front();
                  chk("ev_kind", 32'({frame_ok, frame_err}), e.ok ? 32'd2 : 32'd1);
                  cur_code = e.code;
                  cur_cnt  = e.cnt;
               end
            end
            chk("err_code", 32'(err_code), 32'(cur_code));
            chk("frame_count", 32'(frame_count), 32'(cur_cnt));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_last, bus.out_data};
         end
      end
   end

   task automatic push_ev(input bit ok, input logic [1:0] code);
      ev_t e;
      if (ok) mcount = mcount + 16'd1;
      e.ok = ok; e.code = code; e.cnt = mcount;
      exp_ev.push_back(e);
   endtask

   // Frame-level parse of the whole stimulus stream.
   task automatic model();
      int i = 0;
      int n = stim.size();
      int L;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
      logic [7:0] x;
`endif
      while (i < n) begin
         if (stim[i] != SYNC) begin i++; continue; end
         i++;
         if (i >= n) break;
         L = int'(stim[i]);
         i++;
         if (L == 0 || L > int'(MAX_LEN)) begin push_ev(0, 2'b01); continue; end
         if (i + L > n) break;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
         x = 8'(L);
`endif
         for (int k = 0; k < L; k++) begin
            exp_out.push_back({k == L - 1, stim[i + k]});
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
            x = x ^ stim[i + k];
`endif
         end
         i += L;
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
         if (i >= n) break;
         if (stim[i] == x) push_ev(1, 2'b00);
         else push_ev(0, 2'b10);
         i++;
`else
         push_ev(1, 2'b00);
`endif
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      logic rdy = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
      end
      if (!rdy) chk("accept_timeout", 32'(rdy), 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      rdy_mode = 0;
      for (int t = 0; t < 100 && (exp_out.size() != 0 || exp_ev.size() != 0); t++)
         @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_out", exp_out.size(), 0);
      chk("drain_ev", exp_ev.size(), 0);
      chk("seg_count", 32'(frame_count), 32'(mcount));
      @(posedge clk);
      #1;
   endtask

   task automatic run_seg(input bit gaps);
      model();
      foreach (stim[i]) begin
         if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         send_byte(stim[i]);
      end
      drain();
   endtask

   task automatic gen_random();
      int nfr = $urandom_range(1, 4);
      int L;
      logic [7:0] b;
      logic [7:0] x;
      stim.delete();
      for (int f = 0; f < nfr; f++) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == SYNC) b = b ^ 8'h01;
            stim.push_back(b);
         end
         stim.push_back(SYNC);
         case ($urandom_range(0, 7))
            0: L = 0;
            1: L = 1;
            2: L = int'(MAX_LEN);
            3: L = int'(MAX_LEN) + 1;
            4: L = 255;
            default: L = int'($urandom_range(1, MAX_LEN));
         endcase
         stim.push_back(8'(L));
         if (L == 0 || L > int'(MAX_LEN)) continue;
         x = 8'(L);
         for (int k = 0; k < L; k++) begin
            b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
            stim.push_back(b);
            x = x ^ b;
         end
`ifdef SYNC_FRAME_PARSER_CHECKSUM_EN
         if ($urandom_range(0, 4) == 0) x = x ^ 8'(($urandom_range(1, 255)));
         stim.push_back(x);
`endif
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = SYNC;
      repeat (2) begin
         @(negedge clk);
         chk("rst_in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_out_last", 32'(bus.out_last), 0);
      chk("rst_pulses", 32'({frame_ok, frame_err}), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      @(posedge clk);
      #1;
      mon_en = 1;

      rdy_mode = 0;
      stim = {8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
      run_seg(0);
      stim = {8'hAA, 8'h02, 8'h55, 8'h66, 8'h00};
      run_seg(0);
      stim = {8'h5A, 8'hAA, 8'h00, 8'hAA, 8'h11};
      run_seg(0);
      rdy_mode = 1;
      stim = {8'hAA, 8'h04, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h04};
      run_seg(0);

      for (int s = 0; s < 40; s++) begin
         gen_random();
         rdy_mode = $urandom_range(0, 2);
         run_seg(1);
      end

      // Reset in the middle of a 5-byte payload with one byte buffered.
      rdy_mode = 0;
      exp_out.push_back({1'b0, 8'h10});
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h10);
      for (int t = 0; t < 50 && exp_out.size() != 0; t++) @(negedge clk);
      chk("pre_rst_drain", exp_out.size(), 0);
      @(posedge clk);
      #1;
      rdy_mode = 3;
      repeat (2) begin @(posedge clk); #1; end
      send_byte(8'h20);
      @(negedge clk);
      chk("rst_buffered", 32'(bus.out_valid), 1);
      mon_en = 0;
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = SYNC;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_pulses", 32'({frame_ok, frame_err}), 0);
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
         chk("mid_rst_frame_err", 32'(frame_err), 0);
      end
      bus.in_valid = 1'b0;
      rst = 1'b0;
      rdy_mode = 0;
      exp_out.delete();
      exp_ev.delete();
      mcount = '0;
      cur_code = '0;
      cur_cnt = '0;
      #1;
      chk("post_rst_out_valid", 32'(bus.out_valid), 0);
      chk("post_rst_out_data", 32'(bus.out_data), 0);
      chk("post_rst_out_last", 32'(bus.out_last), 0);
      chk("post_rst_err_code", 32'(err_code), 0);
      chk("post_rst_frame_count", 32'(frame_count), 0);
      @(posedge clk);
      #1;
      mon_en = 1;
      stim = {8'hAA, 8'h01, 8'h7E, 8'h7F};
      run_seg(0);
      chk("post_rst_count", 32'(frame_count), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
